// File: rtl/chip_load_driver.sv
// Host-side loader: streams source words into the chip input/kernel memories, then hands off.
// Optional LOAD_CHECKSUM_EN macro enables the running sum of written data words.
module chip_load_driver #(
    parameter int IO_DATA_WIDTH      = 16,
    parameter int FEATURE_MAP_WIDTH  = 128,
    parameter int FEATURE_MAP_HEIGHT = 128,
    parameter int INPUT_NB_CHANNELS  = 2,
    parameter int OUTPUT_NB_CHANNELS = 16,
    parameter int KERNEL_SIZE        = 3
) (
    input  logic                     clk,
    input  logic                     arst_in,
    input  logic                     go,
    input  logic [IO_DATA_WIDTH-1:0] src_data,
    input  logic                     src_valid,
    output logic                     src_ready,
    output logic [IO_DATA_WIDTH-1:0] a_input,
    output logic [IO_DATA_WIDTH-1:0] b_input,
    output logic                     int_mem_we,
    output logic                     data_ready,
    output logic                     start,
    input  logic                     fsm_done,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              checksum
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_IN, S_LOAD_KER, S_HANDOFF, S_START, S_WAIT_DONE, S_DONE
    } state_t;

    localparam logic [6:0] X_LAST  = 7'(FEATURE_MAP_WIDTH - 1);
    localparam logic [6:0] Y_LAST  = 7'(FEATURE_MAP_HEIGHT - 1);
    localparam logic [0:0] IC_LAST = 1'(INPUT_NB_CHANNELS - 1);
    localparam logic [3:0] OC_LAST = 4'(OUTPUT_NB_CHANNELS - 1);
    localparam logic [1:0] K_LAST  = 2'(KERNEL_SIZE - 1);

    state_t state_q, state_d;
    logic [6:0] x_q, x_d, y_q, y_d;
    logic [0:0] inch_q, inch_d;
    logic [1:0] ky_q, ky_d, kx_q, kx_d;
    logic [3:0] outch_q, outch_d;
    logic [IO_DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic we_q, we_d;
    logic data_ready_q, data_ready_d;
    logic start_q, start_d;
    logic [15:0] addr;
    logic xfer;
    logic launch;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        inch_d       = inch_q;
        ky_d         = ky_q;
        kx_d         = kx_q;
        outch_d      = outch_q;
        addr         = 16'h0000;
        launch       = 1'b0;
        src_ready    = (state_q == S_LOAD_IN) || (state_q == S_LOAD_KER);
        xfer         = src_ready && src_valid;
        data_ready_d = (state_q == S_HANDOFF);
        start_d      = (state_q == S_START);

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (go) begin
                    launch  = 1'b1;
                    state_d = S_LOAD_IN;
                    x_d     = '0;
                    y_d     = '0;
                    inch_d  = '0;
                    ky_d    = '0;
                    kx_d    = '0;
                    outch_d = '0;
                end
            end
            S_LOAD_IN: begin
                addr = {1'b0, inch_q, y_q, x_q};
                // x innermost, carrying into y then channel
                if (xfer) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d = '0;
                            if (inch_q == IC_LAST) begin
                                inch_d  = '0;
                                state_d = S_LOAD_KER;
                            end else begin
                                inch_d = inch_q + 1'b1;
                            end
                        end else begin
                            y_d = y_q + 7'd1;
                        end
                    end else begin
                        x_d = x_q + 7'd1;
                    end
                end
            end
            S_LOAD_KER: begin
                addr = {1'b1, 6'b0, inch_q, ky_q, kx_q, outch_q};
                if (xfer) begin
                    if (outch_q == OC_LAST) begin
                        outch_d = '0;
                        if (kx_q == K_LAST) begin
                            kx_d = '0;
                            if (ky_q == K_LAST) begin
                                ky_d = '0;
                                if (inch_q == IC_LAST) begin
                                    inch_d  = '0;
                                    state_d = S_HANDOFF;
                                end else begin
                                    inch_d = inch_q + 1'b1;
                                end
                            end else begin
                                ky_d = ky_q + 2'd1;
                            end
                        end else begin
                            kx_d = kx_q + 2'd1;
                        end
                    end else begin
                        outch_d = outch_q + 4'd1;
                    end
                end
            end
            S_HANDOFF:   state_d = S_START;
            S_START:     state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (fsm_done) state_d = S_DONE;
            default:     state_d = S_IDLE;
        endcase

        we_d = xfer;
        a_d  = xfer ? IO_DATA_WIDTH'(addr) : a_q;
        b_d  = xfer ? src_data : b_q;
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            inch_q       <= '0;
            ky_q         <= '0;
            kx_q         <= '0;
            outch_q      <= '0;
            a_q          <= '0;
            b_q          <= '0;
            we_q         <= 1'b0;
            data_ready_q <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            inch_q       <= inch_d;
            ky_q         <= ky_d;
            kx_q         <= kx_d;
            outch_q      <= outch_d;
            a_q          <= a_d;
            b_q          <= b_d;
            we_q         <= we_d;
            data_ready_q <= data_ready_d;
            start_q      <= start_d;
        end
    end

`ifdef LOAD_CHECKSUM_EN
    logic [31:0] cks_q, cks_d;

    always_comb begin
        cks_d = cks_q;
        if (launch) begin
            cks_d = '0;
        end else if (xfer) begin
            cks_d = cks_q + 32'(src_data);
        end
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            cks_q <= '0;
        end else begin
            cks_q <= cks_d;
        end
    end

    assign checksum = cks_q;
`else
    assign checksum = 32'h0;
`endif

    assign a_input    = a_q;
    assign b_input    = b_q;
    assign int_mem_we = we_q;
    assign data_ready = data_ready_q;
    assign start      = start_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_chip_load_driver.sv
// Directed bench for chip_load_driver: 4x4 map, 2 in-ch, 4 out-ch, 3x3 kernel (104 words).
module tb_chip_load_driver;

    localparam int NIN  = 32;
    localparam int NTOT = 104;
`ifdef LOAD_CHECKSUM_EN
    localparam logic [31:0] CKS_EXP = 32'd5356;
`else
    localparam logic [31:0] CKS_EXP = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        arst_in = 1'b1;
    logic        go = 1'b0;
    logic [15:0] src_data;
    logic        src_valid;
    logic        src_ready;
    logic [15:0] a_input;
    logic [15:0] b_input;
    logic        int_mem_we;
    logic        data_ready;
    logic        start;
    logic        fsm_done = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    chip_load_driver #(
        .IO_DATA_WIDTH(16),
        .FEATURE_MAP_WIDTH(4),
        .FEATURE_MAP_HEIGHT(4),
        .INPUT_NB_CHANNELS(2),
        .OUTPUT_NB_CHANNELS(4),
        .KERNEL_SIZE(3)
    ) dut (
        .clk(clk),
        .arst_in(arst_in),
        .go(go),
        .src_data(src_data),
        .src_valid(src_valid),
        .src_ready(src_ready),
        .a_input(a_input),
        .b_input(b_input),
        .int_mem_we(int_mem_we),
        .data_ready(data_ready),
        .start(start),
        .fsm_done(fsm_done),
        .busy(busy),
        .done(done),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    // source model: word value = index of word within the current sequence
    logic [15:0] src_idx;
    logic valid_en = 1'b0;
    logic toggle_mode = 1'b0;
    logic src_clr = 1'b0;
    logic phase = 1'b0;

    assign src_valid = valid_en & (~toggle_mode | phase);
    assign src_data  = src_idx;

    always @(negedge clk) phase <= ~phase;

    always @(posedge clk or posedge arst_in) begin
        if (arst_in) src_idx <= '0;
        else if (src_clr) src_idx <= '0;
        else if (src_valid && src_ready) src_idx <= src_idx + 16'd1;
    end

    // write/pulse recorder
    logic [15:0] wr_addr [0:1023];
    logic [15:0] wr_data [0:1023];
    int wr_cyc [0:1023];
    int cyc = 0;
    int wr_n = 0;
    int dr_n = 0;
    int dr_cyc = 0;
    int st_n = 0;
    int st_cyc = 0;
    int ovl = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (int_mem_we) begin
            wr_addr[wr_n] <= a_input;
            wr_data[wr_n] <= b_input;
            wr_cyc[wr_n]  <= cyc;
            wr_n          <= wr_n + 1;
        end
        if (data_ready) begin
            dr_n   <= dr_n + 1;
            dr_cyc <= cyc;
        end
        if (start) begin
            st_n   <= st_n + 1;
            st_cyc <= cyc;
        end
        if (data_ready && int_mem_we) ovl <= ovl + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_go();
        go = 1'b1;
        src_clr = 1'b1;
        step(1);
        go = 1'b0;
        src_clr = 1'b0;
    endtask

    task automatic wait_writes(input int base, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (wr_n - base >= target) break;
            step(1);
        end
        check("wait_writes", wr_n - base, target);
    endtask

    function automatic logic [15:0] exp_addr(input int i);
        int j;
        if (i < NIN) begin
            return 16'(((i / 16) << 14) | (((i / 4) % 4) << 7) | (i % 4));
        end
        j = i - NIN;
        return 16'(32'h8000 | ((j / 36) << 8) | (((j / 12) % 3) << 6)
                   | (((j / 4) % 3) << 4) | (j % 4));
    endfunction

    task automatic check_seq(input int base, input int dr0, input int st0);
        int bad_a;
        int bad_d;
        bad_a = 0;
        bad_d = 0;
        check("total_writes", wr_n - base, NTOT);
        for (int i = 0; i < NTOT; i++) begin
            if (wr_addr[base + i] !== exp_addr(i)) bad_a++;
            if (wr_data[base + i] !== 16'(i)) bad_d++;
        end
        check("addr_order", bad_a, 0);
        check("data_order", bad_d, 0);
        check("data_ready_cnt", dr_n - dr0, 1);
        check("start_cnt", st_n - st0, 1);
        check("data_ready_lat", dr_cyc - wr_cyc[base + NTOT - 1], 1);
        check("start_lat", st_cyc - wr_cyc[base + NTOT - 1], 2);
        check("no_overlap", ovl, 0);
        check("wait_busy", busy, 1);
        check("wait_done", done, 0);
        check("wait_src_ready", src_ready, 0);
        check("checksum", checksum, CKS_EXP);
        fsm_done = 1'b1;
        step(1);
        fsm_done = 1'b0;
        check("done_set", done, 1);
        check("busy_clr", busy, 0);
        step(2);
        check("done_level", done, 1);
    endtask

    int base;
    int dr0;
    int st0;

    initial begin
        valid_en = 1'b1;
        step(2);
        check("rst_src_ready", src_ready, 0);
        check("rst_we", int_mem_we, 0);
        check("rst_data_ready", data_ready, 0);
        check("rst_start", start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_a", a_input, 16'h0000);
        check("rst_b", b_input, 16'h0000);
        check("rst_checksum", checksum, 0);
        arst_in = 1'b0;
        step(2);
        check("idle_src_ready", src_ready, 0);

        // run 1: continuous stream
        base = wr_n;
        dr0 = dr_n;
        st0 = st_n;
        pulse_go();
        check("go_busy", busy, 1);
        wait_writes(base, NTOT, 400);
        step(5);
        check("first_addr", wr_addr[base], 16'h0000);
        check("first_data", wr_data[base], 16'h0000);
        check("w27_addr", wr_addr[base + 27], 16'h4103);
        check("w32_addr", wr_addr[base + 32], 16'h8000);
        check("ker_8193", wr_addr[base + 99], 16'h8193);
        check("last_addr", wr_addr[base + 103], 16'h81A3);
        check("last_data", wr_data[base + 103], 16'd103);
        check_seq(base, dr0, st0);

        // run 2: toggling valid, stray go / fsm_done during load
        toggle_mode = 1'b1;
        base = wr_n;
        dr0 = dr_n;
        st0 = st_n;
        pulse_go();
        step(10);
        go = 1'b1;
        fsm_done = 1'b1;
        step(1);
        go = 1'b0;
        fsm_done = 1'b0;
        check("ignore_busy", busy, 1);
        check("ignore_done", done, 0);
        wait_writes(base, NTOT, 500);
        step(5);
        check_seq(base, dr0, st0);

        // run 3: reset mid-load, then restart
        toggle_mode = 1'b0;
        base = wr_n;
        pulse_go();
        wait_writes(base, 50, 200);
        arst_in = 1'b1;
        #1;
        check("abort_we", int_mem_we, 0);
        check("abort_busy", busy, 0);
        check("abort_src_ready", src_ready, 0);
        check("abort_a", a_input, 16'h0000);
        step(3);
        arst_in = 1'b0;
        step(2);
        check("abort_writes", wr_n - base, 50);
        base = wr_n;
        pulse_go();
        wait_writes(base, 1, 20);
        check("restart_addr", wr_addr[base], 16'h0000);
        check("restart_data", wr_data[base], 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
